mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one WIDTH-bit output channel between four requesters.
- Internally drives the select lines of a 4:1 mux built from 2:1 muxes.
- Grants one requester at a time for a burst, which ends on last, on MAX_BEATS, or when the requester withdraws.
- Sits between four producer ports and a single valid/ready consumer.

---
 rtl/mux4_rr_arbiter.sv | 126 ++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
//
// Round-robin arbiter that shares one WIDTH-bit valid/ready output channel
// between four requesters. A winning requester holds the channel for a burst
// that ends on its last marker, after MAX_BEATS transfers, or when it drops
// its request. The output data goes through a 4:1 mux built from 2:1 muxes
// whose select lines are the registered sel output.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req[3:0]   per-requester request, req[i] means d_i holds a valid beat
//   last[3:0]  per-requester end-of-burst marker, qualified with req[i]
//   d0..d3     requester data, WIDTH bits each
//   out_ready  consumer ready
//   out_valid  beat valid on out_data
//   out_data   data of the requester selected by sel
//   gnt[3:0]   registered one-hot grant (zero while idle)
//   sel[1:0]   registered mux select, index of the granted requester
//   ack[3:0]   per-requester beat accepted this cycle
// ---------------------------------------------------------------------------
module mux4_rr_arbiter #(
   parameter int WIDTH     = 8,
   parameter int MAX_BEATS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       req,
   input  logic [3:0]       last,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic [WIDTH-1:0] d3,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [3:0]       gnt,
   output logic [1:0]       sel,
   output logic [3:0]       ack
);

   // beat_cnt only has to reach MAX_BEATS-1; a burst of one beat still needs
   // a one-bit counter so the comparison below stays well formed.
   localparam int CW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BEATS - 1);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t        state;
   logic [1:0]    ptr;
   logic [CW-1:0] beat_cnt;

   logic [WIDTH-1:0] mux_lo;
   logic [WIDTH-1:0] mux_hi;
   logic             req_sel;
   logic             transfer;
   logic             burst_done;
   logic             pick_found;
   logic [1:0]       pick_idx;

   // Two-level 2:1 mux tree: s0 picks within each pair, s1 picks the pair.
   assign mux_lo   = sel[0] ? d1 : d0;
   assign mux_hi   = sel[0] ? d3 : d2;
   assign out_data = sel[1] ? mux_hi : mux_lo;

   assign req_sel    = req[sel];
   assign out_valid  = (state == BUSY) & req_sel;
   assign transfer   = out_valid & out_ready;
   assign ack        = transfer ? gnt : 4'b0000;
   assign burst_done = transfer & (last[sel] | (beat_cnt == LAST_BEAT));

   // Search for the first pending request starting at ptr and wrapping 3->0.
   // The 2-bit addition wraps by itself, so ptr+k is the rotated index.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = ptr;
      for (int k = 0; k < 4; k++) begin
         if (!pick_found && req[ptr + 2'(k)]) begin
            pick_found = 1'b1;
            pick_idx   = ptr + 2'(k);
         end
      end
   end

   // Grant/release sequencing. sel is left alone on release so the mux keeps
   // pointing at the last owner during the idle bubble; ptr moves one past
   // the released requester so it becomes lowest priority next time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         gnt      <= 4'b0000;
         sel      <= 2'd0;
         ptr      <= 2'd0;
         beat_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  state    <= BUSY;
                  sel      <= pick_idx;
                  gnt      <= 4'b0001 << pick_idx;
                  beat_cnt <= '0;
               end
            end
            BUSY: begin
               if (!req_sel || burst_done) begin
                  state <= IDLE;
                  gnt   <= 4'b0000;
                  ptr   <= sel + 2'd1;
               end else if (transfer) begin
                  beat_cnt <= beat_cnt + CW'(1);
               end
            end
            default: begin
               state <= IDLE;
               gnt   <= 4'b0000;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux4_rr_arbiter
//
// Randomized bench for mux4_rr_arbiter. A transaction-level reference keeps
// the current owner, the round-robin priority and the number of beats sent,
// and predicts every output once per cycle. Includes a reset at start and an
// asynchronous reset in the middle of traffic.
// ---------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

   localparam int WIDTH     = 8;
   localparam int MAX_BEATS = 4;

   logic             clk;
   logic             rst_n;
   logic [3:0]       req;
   logic [3:0]       last;
   logic [WIDTH-1:0] d [4];
   logic             out_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic [3:0]       gnt;
   logic [1:0]       sel;
   logic [3:0]       ack;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: owner is -1 when nobody holds the channel.
   int owner     = -1;
   int prio      = 0;
   int beats     = 0;
   int model_sel = 0;

   mux4_rr_arbiter #(
      .WIDTH    (WIDTH),
      .MAX_BEATS(MAX_BEATS)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .last     (last),
      .d0       (d[0]),
      .d1       (d[1]),
      .d2       (d[2]),
      .d3       (d[3]),
      .out_ready(out_ready),
      .out_valid(out_valid),
      .out_data (out_data),
      .gnt      (gnt),
      .sel      (sel),
      .ack      (ack)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts and reports.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t",
                  tag, observed, expected, $time);
      end
   endtask

   // Random traffic biased toward long-held requests so bursts can reach
   // MAX_BEATS; occasional withdrawals, idle gaps and backpressure.
   task automatic applyStimulus();
      for (int i = 0; i < 4; i++) begin
         req[i]  = ($urandom_range(0, 9) != 0);
         last[i] = ($urandom_range(0, 6) == 0);
         d[i]    = WIDTH'($urandom);
      end
      if ($urandom_range(0, 15) == 0) req = 4'b0000;
      out_ready = ($urandom_range(0, 9) < 7);
   endtask

   // Predict outputs for the current inputs, compare, then advance the
   // reference to what the next clock edge should produce.
   task automatic checkCycle();
      logic [3:0]       exp_gnt;
      logic             exp_valid;
      logic [3:0]       exp_ack;
      logic             xfer;
      exp_gnt   = 4'b0000;
      exp_valid = 1'b0;
      exp_ack   = 4'b0000;
      xfer      = 1'b0;
      if (owner >= 0) begin
         exp_gnt   = 4'(1 << owner);
         exp_valid = req[owner];
         xfer      = exp_valid && out_ready;
         exp_ack   = xfer ? exp_gnt : 4'b0000;
      end
      checkOutput("gnt", 32'(gnt), 32'(exp_gnt));
      checkOutput("sel", 32'(sel), 32'(model_sel));
      checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
      checkOutput("ack", 32'(ack), 32'(exp_ack));
      checkOutput("out_data", 32'(out_data), 32'(d[model_sel]));

      if (owner < 0) begin
         for (int k = 0; k < 4; k++) begin
            if (owner < 0 && req[(prio + k) % 4]) begin
               owner = (prio + k) % 4;
            end
         end
         if (owner >= 0) begin
            beats     = 0;
            model_sel = owner;
         end
      end else if (!req[owner]) begin
         prio  = (owner + 1) % 4;
         owner = -1;
      end else if (xfer) begin
         beats++;
         if (last[owner] || beats == MAX_BEATS) begin
            prio  = (owner + 1) % 4;
            owner = -1;
         end
      end
   endtask

   task automatic resetModel();
      owner     = -1;
      prio      = 0;
      beats     = 0;
      model_sel = 0;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_gnt"}, 32'(gnt), 32'h0);
      checkOutput({tag, "_valid"}, 32'(out_valid), 32'h0);
      checkOutput({tag, "_ack"}, 32'(ack), 32'h0);
      checkOutput({tag, "_sel"}, 32'(sel), 32'h0);
      checkOutput({tag, "_data"}, 32'(out_data), 32'(d[0]));
   endtask

   initial begin
      bit force_all;
      force_all = 1'b0;

      // Power-on reset with all requesters asking.
      rst_n = 1'b0;
      applyStimulus();
      req = 4'b1111;
      #2;
      checkResetState("por");
      resetModel();
      req = 4'b0000;
      @(posedge clk);
      #3 rst_n = 1'b1;

      for (int phase = 0; phase < 2; phase++) begin
         for (int cyc = 0; cyc < 2500; cyc++) begin
            @(posedge clk);
            #1;
            applyStimulus();
            if (force_all) begin
               req       = 4'b1111;
               force_all = 1'b0;
            end
            #3;
            checkCycle();
         end

         if (phase == 0) begin
            // Asynchronous reset in the middle of traffic: outputs must drop
            // immediately, and the first grant afterwards goes to requester 0.
            @(posedge clk);
            #1;
            applyStimulus();
            req = 4'b1111;
            #2 rst_n = 1'b0;
            #1;
            checkResetState("midrst");
            resetModel();
            req = 4'b0000;
            @(posedge clk);
            #3 rst_n = 1'b1;
            force_all = 1'b1;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
